mem_stage: RTL and testbench

Memory stage of the 16-bit pipelined core, directly downstream of the execute-stage ALU. Consumes the ALU result, store data, PC and condition-code flags. Performs data-memory loads/stores and stack operations (PUSH/POP/CALL/RET/INT/RTI) against an internal word-addressed data memory and stack pointer. Drives a registered MEM/WB interface plus PC-redirect and CCR-restore strobes. Two-word operations (INT, RTI) run as a two-cycle sequence and stall the pipeline for one cycle.

---
 rtl/mem_stage_pkg.sv | 28 ++
 rtl/mem_stage_if.sv | 39 +++
 rtl/mem_stage_data_mem.sv | 25 ++
 rtl/mem_stage.sv | 199 +++++++++++++++++++
 tb/tb_mem_stage.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: opcode encoding and CCR layout.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_PUSH  = 4'd3,
        OP_POP   = 4'd4,
        OP_CALL  = 4'd5,
        OP_RET   = 4'd6,
        OP_INT   = 4'd7,
        OP_RTI   = 4'd8
    } mem_op_t;

    localparam int CCR_W = 3;

    // Flag positions match the execute-stage ALU flag output.
    localparam int CCR_C = 2;
    localparam int CCR_N = 1;
    localparam int CCR_Z = 0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Execute-to-memory request bundle and the MEM/WB result bundle of the memory stage.
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
);
    logic              in_valid;
    logic [3:0]        mem_op;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] pc_in;
    logic [CCR_W-1:0]  ccr_in;
    logic [2:0]        rd_in;
    logic              wb_en_in;

    logic              stall_out;
    logic              out_valid;
    logic [DATA_W-1:0] wb_data;
    logic [2:0]        rd_out;
    logic              wb_en_out;
    logic              pc_load;
    logic [DATA_W-1:0] pc_target;
    logic              ccr_load;
    logic [CCR_W-1:0]  ccr_restore;
    logic [ADDR_W-1:0] sp_out;

    modport master (
        output in_valid, mem_op, alu_result, store_data, pc_in, ccr_in, rd_in, wb_en_in,
        input  stall_out, out_valid, wb_data, rd_out, wb_en_out, pc_load, pc_target,
               ccr_load, ccr_restore, sp_out
    );

    modport slave (
        input  in_valid, mem_op, alu_result, store_data, pc_in, ccr_in, rd_in, wb_en_in,
        output stall_out, out_valid, wb_data, rd_out, wb_en_out, pc_load, pc_target,
               ccr_load, ccr_restore, sp_out
    );
endinterface

// File: rtl/mem_stage_data_mem.sv
// Word-addressed data memory: one synchronous write port, two combinational read ports.
module data_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr [2],
    output logic [DATA_W-1:0] rdata [2]
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Port 0 serves LOAD addresses, port 1 serves the top-of-stack (SP+1).
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        assign rdata[gi] = mem[raddr[gi]];
    end
endmodule

// File: rtl/mem_stage.sv
// Memory stage: loads/stores, stack ops and the two-cycle INT/RTI sequence, registered MEM/WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 11,
    parameter int SP_RESET = 2**ADDR_W - 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_stage_if.slave      bus
);
    mem_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] sp_reg, sp_next;
    logic              second_rti_reg, second_rti_next;
    logic [CCR_W-1:0]  ccr_hold_reg, ccr_hold_next;

    logic              out_valid_reg, out_valid_next;
    logic [DATA_W-1:0] wb_data_reg, wb_data_next;
    logic [2:0]        rd_out_reg, rd_out_next;
    logic              wb_en_out_reg, wb_en_out_next;
    logic              pc_load_reg, pc_load_next;
    logic [DATA_W-1:0] pc_target_reg, pc_target_next;
    logic              ccr_load_reg, ccr_load_next;
    logic [CCR_W-1:0]  ccr_restore_reg, ccr_restore_next;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr [2];
    logic [DATA_W-1:0] mem_rdata [2];

    logic [ADDR_W-1:0] sp_plus1;
    logic [ADDR_W-1:0] sp_minus1;
    logic [DATA_W-1:0] top_word;
    logic              stall;
    logic              fire;

    assign sp_plus1     = sp_reg + ADDR_W'(1);
    assign sp_minus1    = sp_reg - ADDR_W'(1);
    assign mem_raddr[0] = bus.alu_result[ADDR_W-1:0];
    assign mem_raddr[1] = sp_plus1;
    assign top_word     = mem_rdata[1];

    data_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_next       = state_reg;
        sp_next          = sp_reg;
        second_rti_next  = second_rti_reg;
        ccr_hold_next    = ccr_hold_reg;
        wb_data_next     = wb_data_reg;
        pc_load_next     = 1'b0;
        pc_target_next   = pc_target_reg;
        ccr_load_next    = 1'b0;
        ccr_restore_next = ccr_restore_reg;
        mem_we           = 1'b0;
        mem_waddr        = sp_reg;
        mem_wdata        = bus.store_data;
        stall            = 1'b0;
        fire             = 1'b0;

        if (state_reg == ST_IDLE) begin
            if (bus.in_valid) begin
                fire         = 1'b1;
                wb_data_next = bus.alu_result;
                case (bus.mem_op)
                    OP_LOAD: begin
                        wb_data_next = mem_rdata[0];
                    end
                    OP_STORE: begin
                        mem_we    = 1'b1;
                        mem_waddr = bus.alu_result[ADDR_W-1:0];
                    end
                    OP_PUSH: begin
                        mem_we  = 1'b1;
                        sp_next = sp_minus1;
                    end
                    OP_POP: begin
                        wb_data_next = top_word;
                        sp_next      = sp_plus1;
                    end
                    OP_CALL: begin
                        mem_we         = 1'b1;
                        mem_wdata      = bus.pc_in;
                        sp_next        = sp_minus1;
                        pc_load_next   = 1'b1;
                        pc_target_next = bus.alu_result;
                    end
                    OP_RET: begin
                        sp_next        = sp_plus1;
                        pc_load_next   = 1'b1;
                        pc_target_next = top_word;
                    end
                    OP_INT: begin
                        fire            = 1'b0;
                        wb_data_next    = wb_data_reg;
                        stall           = 1'b1;
                        state_next      = ST_SECOND;
                        second_rti_next = 1'b0;
                        mem_we          = 1'b1;
                        mem_wdata       = bus.pc_in;
                        sp_next         = sp_minus1;
                    end
                    OP_RTI: begin
                        fire                 = 1'b0;
                        wb_data_next         = wb_data_reg;
                        stall                = 1'b1;
                        state_next           = ST_SECOND;
                        second_rti_next      = 1'b1;
                        ccr_hold_next[CCR_C] = top_word[CCR_C];
                        ccr_hold_next[CCR_N] = top_word[CCR_N];
                        ccr_hold_next[CCR_Z] = top_word[CCR_Z];
                        sp_next              = sp_plus1;
                    end
                    default: begin
                    end
                endcase
            end
        end else begin
            // Second word of INT/RTI; the upstream stage is holding its inputs.
            state_next     = ST_IDLE;
            fire           = 1'b1;
            wb_data_next   = bus.alu_result;
            pc_load_next   = 1'b1;
            if (second_rti_reg) begin
                sp_next          = sp_plus1;
                pc_target_next   = top_word;
                ccr_load_next    = 1'b1;
                ccr_restore_next = ccr_hold_reg;
            end else begin
                mem_we         = 1'b1;
                mem_wdata      = {{(DATA_W-CCR_W){1'b0}}, bus.ccr_in};
                sp_next        = sp_minus1;
                pc_target_next = bus.alu_result;
            end
        end

        // Reset abandons any half-done sequence, including its memory write.
        if (rst) begin
            mem_we = 1'b0;
        end

        out_valid_next = fire;
        rd_out_next    = fire ? bus.rd_in : rd_out_reg;
        wb_en_out_next = fire & bus.wb_en_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            sp_reg          <= ADDR_W'(SP_RESET);
            second_rti_reg  <= 1'b0;
            ccr_hold_reg    <= '0;
            out_valid_reg   <= 1'b0;
            wb_data_reg     <= '0;
            rd_out_reg      <= '0;
            wb_en_out_reg   <= 1'b0;
            pc_load_reg     <= 1'b0;
            pc_target_reg   <= '0;
            ccr_load_reg    <= 1'b0;
            ccr_restore_reg <= '0;
        end else begin
            state_reg       <= state_next;
            sp_reg          <= sp_next;
            second_rti_reg  <= second_rti_next;
            ccr_hold_reg    <= ccr_hold_next;
            out_valid_reg   <= out_valid_next;
            wb_data_reg     <= wb_data_next;
            rd_out_reg      <= rd_out_next;
            wb_en_out_reg   <= wb_en_out_next;
            pc_load_reg     <= pc_load_next;
            pc_target_reg   <= pc_target_next;
            ccr_load_reg    <= ccr_load_next;
            ccr_restore_reg <= ccr_restore_next;
        end
    end

    assign bus.stall_out   = stall;
    assign bus.out_valid   = out_valid_reg;
    assign bus.wb_data     = wb_data_reg;
    assign bus.rd_out      = rd_out_reg;
    assign bus.wb_en_out   = wb_en_out_reg;
    assign bus.pc_load     = pc_load_reg;
    assign bus.pc_target   = pc_target_reg;
    assign bus.ccr_load    = ccr_load_reg;
    assign bus.ccr_restore = ccr_restore_reg;
    assign bus.sp_out      = sp_reg;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed expectations checked with immediate assertions.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_stage_if #(.DATA_W(16), .ADDR_W(11)) bus ();

    mem_stage #(.DATA_W(16), .ADDR_W(11), .SP_RESET(2047)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] alu, input logic [15:0] sd,
                         input logic [15:0] pc, input logic [2:0] ccr, input logic [2:0] rd,
                         input logic wben);
        bus.in_valid   = 1'b1;
        bus.mem_op     = op;
        bus.alu_result = alu;
        bus.store_data = sd;
        bus.pc_in      = pc;
        bus.ccr_in     = ccr;
        bus.rd_in      = rd;
        bus.wb_en_in   = wben;
        $display("drive op=%0d alu=%h sd=%h pc=%h ccr=%b rd=%0d wben=%b",
                 op, alu, sd, pc, ccr, rd, wben);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.mem_op   = OP_NONE;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.in_valid   = 1'b0;
        bus.mem_op     = OP_NONE;
        bus.alu_result = '0;
        bus.store_data = '0;
        bus.pc_in      = '0;
        bus.ccr_in     = '0;
        bus.rd_in      = '0;
        bus.wb_en_in   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_wb_en", 32'(bus.wb_en_out), 32'h0);
        check("rst_pc_load", 32'(bus.pc_load), 32'h0);
        check("rst_ccr_load", 32'(bus.ccr_load), 32'h0);
        check("rst_stall", 32'(bus.stall_out), 32'h0);
        check("rst_sp", 32'(bus.sp_out), 32'd2047);
        check("rst_wb_data", 32'(bus.wb_data), 32'h0);
        check("rst_pc_target", 32'(bus.pc_target), 32'h0);
        check("rst_ccr_restore", 32'(bus.ccr_restore), 32'h0);
        check("rst_rd_out", 32'(bus.rd_out), 32'h0);
        rst = 1'b0;

        // STORE then LOAD
        drive(OP_STORE, 16'h0005, 16'hBEEF, 16'h0, 3'b0, 3'd1, 1'b0);
        tick();
        check("store_valid", 32'(bus.out_valid), 32'h1);
        check("store_wb_en", 32'(bus.wb_en_out), 32'h0);
        drive(OP_LOAD, 16'h0005, 16'h0, 16'h0, 3'b0, 3'd3, 1'b1);
        tick();
        check("load_data", 32'(bus.wb_data), 32'hBEEF);
        check("load_valid", 32'(bus.out_valid), 32'h1);
        check("load_rd", 32'(bus.rd_out), 32'd3);
        check("load_wb_en", 32'(bus.wb_en_out), 32'h1);
        idle();
        tick();
        check("idle_valid", 32'(bus.out_valid), 32'h0);
        check("idle_wb_en", 32'(bus.wb_en_out), 32'h0);
        check("idle_sp", 32'(bus.sp_out), 32'd2047);

        // PUSH, PUSH, POP, POP, then PUSH right after POP
        drive(OP_PUSH, 16'h0, 16'h1234, 16'h0, 3'b0, 3'd0, 1'b0);
        tick();
        check("push1_sp", 32'(bus.sp_out), 32'd2046);
        drive(OP_PUSH, 16'h0, 16'h5678, 16'h0, 3'b0, 3'd0, 1'b0);
        tick();
        check("push2_sp", 32'(bus.sp_out), 32'd2045);
        drive(OP_POP, 16'h0, 16'h0, 16'h0, 3'b0, 3'd2, 1'b1);
        tick();
        check("pop1_data", 32'(bus.wb_data), 32'h5678);
        check("pop1_sp", 32'(bus.sp_out), 32'd2046);
        drive(OP_POP, 16'h0, 16'h0, 16'h0, 3'b0, 3'd4, 1'b1);
        tick();
        check("pop2_data", 32'(bus.wb_data), 32'h1234);
        check("pop2_sp", 32'(bus.sp_out), 32'd2047);
        check("pop2_rd", 32'(bus.rd_out), 32'd4);
        drive(OP_PUSH, 16'h0, 16'h1111, 16'h0, 3'b0, 3'd0, 1'b0);
        tick();
        check("push3_sp", 32'(bus.sp_out), 32'd2046);
        drive(OP_POP, 16'h0, 16'h0, 16'h0, 3'b0, 3'd1, 1'b1);
        tick();
        check("pop3_data", 32'(bus.wb_data), 32'h1111);
        check("pop3_sp", 32'(bus.sp_out), 32'd2047);

        // CALL then RET
        drive(OP_CALL, 16'h0200, 16'h0, 16'h0010, 3'b0, 3'd0, 1'b0);
        tick();
        check("call_pc_load", 32'(bus.pc_load), 32'h1);
        check("call_target", 32'(bus.pc_target), 32'h0200);
        check("call_sp", 32'(bus.sp_out), 32'd2046);
        drive(OP_RET, 16'h0, 16'h0, 16'h0, 3'b0, 3'd0, 1'b0);
        tick();
        check("ret_pc_load", 32'(bus.pc_load), 32'h1);
        check("ret_target", 32'(bus.pc_target), 32'h0010);
        check("ret_sp", 32'(bus.sp_out), 32'd2047);
        idle();
        tick();
        check("ret_pc_pulse", 32'(bus.pc_load), 32'h0);

        // INT: two pushes, one stall cycle
        drive(OP_INT, 16'h0100, 16'h0, 16'h0033, 3'b101, 3'd0, 1'b0);
        #1;
        check("int_stall_a", 32'(bus.stall_out), 32'h1);
        tick();
        check("int_a_valid", 32'(bus.out_valid), 32'h0);
        check("int_a_pc_load", 32'(bus.pc_load), 32'h0);
        check("int_a_sp", 32'(bus.sp_out), 32'd2046);
        check("int_stall_b", 32'(bus.stall_out), 32'h0);
        tick();
        check("int_pc_load", 32'(bus.pc_load), 32'h1);
        check("int_target", 32'(bus.pc_target), 32'h0100);
        check("int_sp", 32'(bus.sp_out), 32'd2045);
        check("int_valid", 32'(bus.out_valid), 32'h1);
        idle();
        tick();
        check("int_pulse", 32'(bus.pc_load), 32'h0);

        // RTI: restore CCR then PC
        drive(OP_RTI, 16'h0, 16'h0, 16'h0, 3'b0, 3'd0, 1'b0);
        #1;
        check("rti_stall_a", 32'(bus.stall_out), 32'h1);
        tick();
        check("rti_a_sp", 32'(bus.sp_out), 32'd2046);
        check("rti_a_ccr_load", 32'(bus.ccr_load), 32'h0);
        tick();
        check("rti_ccr_load", 32'(bus.ccr_load), 32'h1);
        check("rti_pc_load", 32'(bus.pc_load), 32'h1);
        check("rti_ccr", 32'(bus.ccr_restore), 32'b101);
        check("rti_target", 32'(bus.pc_target), 32'h0033);
        check("rti_sp", 32'(bus.sp_out), 32'd2047);
        idle();
        tick();
        check("rti_ccr_pulse", 32'(bus.ccr_load), 32'h0);

        // Undefined opcode behaves as NONE
        drive(4'd12, 16'h4242, 16'h0, 16'h0, 3'b0, 3'd6, 1'b1);
        tick();
        check("nop_data", 32'(bus.wb_data), 32'h4242);
        check("nop_valid", 32'(bus.out_valid), 32'h1);
        check("nop_sp", 32'(bus.sp_out), 32'd2047);

        // SP wrap: POP from 2047 reads mem[0], PUSH from 0 wraps back
        drive(OP_STORE, 16'h0000, 16'h0ABC, 16'h0, 3'b0, 3'd0, 1'b0);
        tick();
        drive(OP_POP, 16'h0, 16'h0, 16'h0, 3'b0, 3'd0, 1'b1);
        tick();
        check("wrap_pop_data", 32'(bus.wb_data), 32'h0ABC);
        check("wrap_pop_sp", 32'(bus.sp_out), 32'd0);
        drive(OP_PUSH, 16'h0, 16'h7777, 16'h0, 3'b0, 3'd0, 1'b0);
        tick();
        check("wrap_push_sp", 32'(bus.sp_out), 32'd2047);

        // Reset during INT cycle B
        drive(OP_INT, 16'h0300, 16'h0, 16'h0044, 3'b010, 3'd0, 1'b0);
        tick();
        check("rstb_a_sp", 32'(bus.sp_out), 32'd2046);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstb_sp", 32'(bus.sp_out), 32'd2047);
        check("rstb_pc_load", 32'(bus.pc_load), 32'h0);
        check("rstb_valid", 32'(bus.out_valid), 32'h0);
        drive(OP_LOAD, 16'h0005, 16'h0, 16'h0, 3'b0, 3'd5, 1'b1);
        tick();
        check("rstb_load_data", 32'(bus.wb_data), 32'hBEEF);
        check("rstb_load_valid", 32'(bus.out_valid), 32'h1);
        check("rstb_no_pc_load", 32'(bus.pc_load), 32'h0);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
